// File: rtl/booth_mul_seq_pkg.sv
// booth_mul_seq_pkg: shared FSM states, Booth op-codes and counter sizing for the Booth multiplier
package booth_mul_seq_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} booth_state_t;

    typedef enum logic [1:0] {OP_NOP, OP_ADD, OP_SUB} booth_op_t;

    // Counter must hold W1-1 = WIDTH.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/booth_mul_seq_if.sv
// booth_mul_seq_if: operand/product valid-ready bus of the Booth multiplier
//   in_valid/in_ready/in_signed/in_mcand/in_mplier : operand handshake (master -> slave)
//   out_valid/out_ready/out_prod                   : product handshake (slave -> master)
interface booth_mul_seq_if #(parameter int WIDTH = 16);

    logic                   in_valid;
    logic                   in_ready;
    logic                   in_signed;
    logic [WIDTH-1:0]       in_mcand;
    logic [WIDTH-1:0]       in_mplier;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*WIDTH-1:0]     out_prod;

    modport master (
        output in_valid, in_signed, in_mcand, in_mplier, out_ready,
        input  in_ready, out_valid, out_prod
    );

    modport slave (
        input  in_valid, in_signed, in_mcand, in_mplier, out_ready,
        output in_ready, out_valid, out_prod
    );

endinterface

// File: rtl/booth_mul_seq_step.sv
// booth_step: one combinational radix-2 Booth iteration (add/sub then arithmetic right shift)
//   a_i, q_i, q_m1_i, m_i : current accumulator, multiplier, Booth bit, multiplicand
//   a_o, q_o, q_m1_o      : next {A,Q,q_m1}
module booth_step
    import booth_mul_seq_pkg::*;
#(
    parameter int W1 = 17
) (
    input  logic [W1-1:0] a_i,
    input  logic [W1-1:0] q_i,
    input  logic          q_m1_i,
    input  logic [W1-1:0] m_i,
    output logic [W1-1:0] a_o,
    output logic [W1-1:0] q_o,
    output logic          q_m1_o
);

    booth_op_t     op;
    logic [W1-1:0] sum;

    always_comb begin
        op  = {q_i[0], q_m1_i} == 2'b01 ? OP_ADD :
              {q_i[0], q_m1_i} == 2'b10 ? OP_SUB : OP_NOP;
        sum = op == OP_ADD ? a_i + m_i :
              op == OP_SUB ? a_i - m_i : a_i;
        // Shift {sum,Q,q_m1} right by one, replicating the sign bit of sum.
        {a_o, q_o, q_m1_o} = {sum[W1-1], sum, q_i};
    end

endmodule

// File: rtl/booth_mul_seq.sv
// booth_mul_seq: sequential radix-2 Booth multiplier, signed/unsigned per transaction
//   clk, rst : clock, asynchronous active-high reset
//   bus      : operand and product valid/ready handshakes (booth_mul_seq_if.slave)
module booth_mul_seq
    import booth_mul_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic            clk,
    input  logic            rst,
    booth_mul_seq_if.slave  bus
);

    localparam int W1 = WIDTH + 1;
    localparam int CW = cnt_w(WIDTH);

    booth_state_t       state_q, state_d;
    logic [W1-1:0]      a_q, a_d, q_q, q_d, m_q, m_d, a_n, q_n;
    logic               qm1_q, qm1_d, qm1_n;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;

    booth_step #(.W1(W1)) u_step (
        .a_i    (a_q),
        .q_i    (q_q),
        .q_m1_i (qm1_q),
        .m_i    (m_q),
        .a_o    (a_n),
        .q_o    (q_n),
        .q_m1_o (qm1_n)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        qm1_d   = qm1_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                state_d = RUN;
                // One extra bit lets unsigned operands ride the signed datapath.
                m_d     = {bus.in_signed & bus.in_mcand[WIDTH-1], bus.in_mcand};
                q_d     = {bus.in_signed & bus.in_mplier[WIDTH-1], bus.in_mplier};
                a_d     = '0;
                qm1_d   = 1'b0;
                cnt_d   = CW'(W1 - 1);
            end
            RUN: begin
                a_d   = a_n;
                q_d   = q_n;
                qm1_d = qm1_n;
                if (cnt_q == '0) begin
                    state_d = DONE;
                    prod_d  = {a_n[WIDTH-2:0], q_n};
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            m_q     <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            qm1_q   <= qm1_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
        end
    end

    assign bus.in_ready  = state_q == IDLE;
    assign bus.out_valid = state_q == DONE;
    assign bus.out_prod  = prod_q;

endmodule

// File: tb/tb_booth_mul_seq.sv
// tb_booth_mul_seq: scoreboard bench for booth_mul_seq at WIDTH=16 and WIDTH=4
module tb_booth_mul_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    logic [31:0] exp16_q[$];
    logic [31:0] exp4_q[$];
    int          acc_q[$];

    typedef struct {
        logic        sg;
        logic [15:0] mc;
        logic [15:0] mp;
        logic [31:0] p;
    } case_t;

    case_t corner_tbl [5] = '{
        '{1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001},
        '{1'b1, 16'hFFFF, 16'hFFFF, 32'h00000001},
        '{1'b1, 16'h8000, 16'h8000, 32'h40000000},
        '{1'b1, 16'h8000, 16'h7FFF, 32'hC0008000},
        '{1'b0, 16'h8000, 16'h8000, 32'h40000000}
    };

    booth_mul_seq_if #(.WIDTH(16)) b16 ();
    booth_mul_seq_if #(.WIDTH(4))  b4 ();

    booth_mul_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(b16));
    booth_mul_seq #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus(b4));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Integer reference: interpret operands at width w, multiply, keep 2w bits.
    function automatic logic [31:0] ref_mul(input logic sg, input logic [15:0] mc, input logic [15:0] mp, input int w);
        longint a, b, p;
        a = longint'(mc);
        b = longint'(mp);
        if (sg && mc[w-1]) a = a - (longint'(1) << w);
        if (sg && mp[w-1]) b = b - (longint'(1) << w);
        p = a * b;
        return 32'(p & ((longint'(1) << (2 * w)) - 1));
    endfunction

    task automatic send16(input logic sg, input logic [15:0] mc, input logic [15:0] mp, output bit ok);
        int n = 0;
        b16.in_signed = sg;
        b16.in_mcand  = mc;
        b16.in_mplier = mp;
        b16.in_valid  = 1'b1;
        while (!b16.in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        ok = b16.in_ready;
        @(posedge clk); #1;
        b16.in_valid = 1'b0;
    endtask

    task automatic wait16(output int lat, output bit ok);
        lat = 0;
        while (!b16.out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        ok = b16.out_valid;
    endtask

    task automatic drain16();
        b16.out_ready = 1'b1;
        @(posedge clk); #1;
        b16.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        total_cnt++;
        if (b16.in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b want=1", b16.in_ready);
        else pass_cnt++;
        total_cnt++;
        if (b16.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b want=0", b16.out_valid);
        else pass_cnt++;
        total_cnt++;
        if (b16.out_prod !== 32'h0) $display("FAIL reset_out_prod got=%h want=00000000", b16.out_prod);
        else pass_cnt++;
    endtask

    task automatic test_signed();
        bit ok1, ok2;
        int lat;
        logic [31:0] e;
        exp16_q.push_back(32'hFFFFFFF1);
        send16(1'b1, 16'hFFFB, 16'h0003, ok1);
        wait16(lat, ok2);
        e = exp16_q.pop_front();
        total_cnt++;
        if (!(ok1 && ok2) || b16.out_prod !== e) $display("FAIL signed_m5x3 got=%h want=%h", b16.out_prod, e);
        else pass_cnt++;
        total_cnt++;
        if (lat !== 17) $display("FAIL signed_latency got=%0d want=17", lat);
        else pass_cnt++;
        drain16();
    endtask

    task automatic test_corners();
        for (int i = 0; i < 5; i++) begin
            bit ok1, ok2;
            int lat;
            logic [31:0] e;
            exp16_q.push_back(corner_tbl[i].p);
            send16(corner_tbl[i].sg, corner_tbl[i].mc, corner_tbl[i].mp, ok1);
            wait16(lat, ok2);
            e = exp16_q.pop_front();
            total_cnt++;
            if (!(ok1 && ok2) || b16.out_prod !== e)
                $display("FAIL corner_%0d s=%b %h*%h got=%h want=%h", i, corner_tbl[i].sg,
                         corner_tbl[i].mc, corner_tbl[i].mp, b16.out_prod, e);
            else pass_cnt++;
            drain16();
        end
    endtask

    task automatic test_backpressure();
        bit ok1, ok2;
        int lat;
        logic [31:0] e, held;
        bit bad = 0;
        exp16_q.push_back(ref_mul(1'b0, 16'h1234, 16'h5678, 16));
        send16(1'b0, 16'h1234, 16'h5678, ok1);
        wait16(lat, ok2);
        e = exp16_q.pop_front();
        total_cnt++;
        if (!(ok1 && ok2) || b16.out_prod !== e) $display("FAIL bp_product got=%h want=%h", b16.out_prod, e);
        else pass_cnt++;
        held = b16.out_prod;
        for (int i = 0; i < 10; i++) begin
            b16.in_valid  = (i % 2 == 0);
            b16.in_mcand  = 16'hAAAA;
            b16.in_mplier = 16'h5555;
            @(posedge clk); #1;
            total_cnt++;
            if (b16.out_prod !== held || b16.in_ready !== 1'b0 || b16.out_valid !== 1'b1)
                $display("FAIL bp_hold_%0d prod=%h rdy=%b vld=%b want prod=%h rdy=0 vld=1",
                         i, b16.out_prod, b16.in_ready, b16.out_valid, held);
            else pass_cnt++;
        end
        b16.in_valid = 1'b0;
        drain16();
        total_cnt++;
        if (b16.in_ready !== 1'b1 || b16.out_valid !== 1'b0)
            $display("FAIL bp_drain rdy=%b vld=%b want rdy=1 vld=0", b16.in_ready, b16.out_valid);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (b16.in_ready !== 1'b1 || b16.out_valid !== 1'b0) bad = 1;
        end
        total_cnt++;
        if (bad) $display("FAIL bp_no_accept got=busy want=idle");
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_run();
        bit ok1, ok2;
        int lat;
        logic [31:0] e;
        bit seen = 0;
        send16(1'b0, 16'h1111, 16'h2222, ok1);
        repeat (8) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        total_cnt++;
        if (!ok1 || b16.in_ready !== 1'b1 || b16.out_valid !== 1'b0)
            $display("FAIL midrst_outputs rdy=%b vld=%b want rdy=1 vld=0", b16.in_ready, b16.out_valid);
        else pass_cnt++;
        total_cnt++;
        if ({dut16.a_q, dut16.q_q, dut16.qm1_q, dut16.m_q, dut16.cnt_q, dut16.prod_q} !== '0)
            $display("FAIL midrst_regs a=%h q=%h m=%h cnt=%0d prod=%h want all 0",
                     dut16.a_q, dut16.q_q, dut16.m_q, dut16.cnt_q, dut16.prod_q);
        else pass_cnt++;
        #2;
        rst = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (b16.out_valid) seen = 1;
        end
        total_cnt++;
        if (seen) $display("FAIL midrst_no_pulse got=out_valid want=none");
        else pass_cnt++;
        exp16_q.push_back(32'd21);
        send16(1'b0, 16'd3, 16'd7, ok1);
        wait16(lat, ok2);
        e = exp16_q.pop_front();
        total_cnt++;
        if (!(ok1 && ok2) || b16.out_prod !== e) $display("FAIL midrst_3x7 got=%h want=%h", b16.out_prod, e);
        else pass_cnt++;
        drain16();
    endtask

    task automatic test_sweep4();
        int got = 0;
        bit drv_to = 0;
        b4.out_ready = 1'b1;
        fork
            begin
                for (int m = 0; m < 2; m++) begin
                    for (int i = 0; i < 256; i++) begin
                        int n = 0;
                        b4.in_signed = m[0];
                        b4.in_mcand  = i[7:4];
                        b4.in_mplier = i[3:0];
                        b4.in_valid  = 1'b1;
                        while (!b4.in_ready && n < 50) begin
                            @(posedge clk); #1;
                            n++;
                        end
                        if (!b4.in_ready) drv_to = 1;
                        exp4_q.push_back(ref_mul(m[0], {12'b0, i[7:4]}, {12'b0, i[3:0]}, 4));
                        acc_q.push_back(cyc + 1);
                        @(posedge clk); #1;
                    end
                end
                b4.in_valid = 1'b0;
            end
            begin
                int guard = 0;
                while (got < 512 && guard < 20000) begin
                    @(posedge clk); #1;
                    guard++;
                    if (b4.out_valid) begin
                        logic [31:0] e;
                        int a;
                        if (exp4_q.size() == 0) begin
                            total_cnt++;
                            $display("FAIL sweep_spurious got=%h want=no output", b4.out_prod);
                        end else begin
                            e = exp4_q.pop_front();
                            a = acc_q.pop_front();
                            total_cnt++;
                            if (b4.out_prod !== e[7:0]) $display("FAIL sweep_prod_%0d got=%h want=%h", got, b4.out_prod, e[7:0]);
                            else pass_cnt++;
                            total_cnt++;
                            if (cyc - a !== 5) $display("FAIL sweep_latency_%0d got=%0d want=5", got, cyc - a);
                            else pass_cnt++;
                            got++;
                        end
                    end
                end
            end
        join
        b4.out_ready = 1'b0;
        total_cnt++;
        if (got != 512 || drv_to) $display("FAIL sweep_count got=%0d want=512 stall=%b", got, drv_to);
        else pass_cnt++;
    endtask

    initial begin
        b16.in_valid = 1'b0; b16.in_signed = 1'b0; b16.in_mcand = '0; b16.in_mplier = '0; b16.out_ready = 1'b0;
        b4.in_valid  = 1'b0; b4.in_signed  = 1'b0; b4.in_mcand  = '0; b4.in_mplier  = '0; b4.out_ready  = 1'b0;
        test_reset();
        test_signed();
        test_corners();
        test_backpressure();
        test_reset_mid_run();
        test_sweep4();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
